c_wpack: RTL and testbench

//  Conv weight loader front end. Packs a byte-serial weight stream into DN-byte words.

---
 rtl/c_pkg.sv | 11 +
 rtl/c_bpack.sv | 42 ++++
 rtl/c_wpack.sv | 142 ++++++++++++++
 tb/tb_c_wpack.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/c_pkg.sv
// Shared defaults and FSM state type for the conv weight loader front end.
package c_pkg;
    localparam int unsigned C_DW = 8;
    localparam int unsigned C_DN = 7;
    localparam int unsigned C_AW = 14;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;
endpackage

// File: rtl/c_bpack.sv
// Byte packer: collects DN bytes into one word, flags the byte that completes it.
module c_bpack
    import c_pkg::*;
#(
    parameter int unsigned DW = C_DW,
    parameter int unsigned DN = C_DN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    in_byte,
    input  logic             load,
    output logic             full,
    output logic [DW*DN-1:0] word
);
    localparam int unsigned BW = (DN > 1) ? $clog2(DN) : 1;

    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [DW*DN-1:0] pack_q, pack_d;

    always_comb begin
        bcnt_d = bcnt_q;
        pack_d = pack_q;
        full   = load && (bcnt_q == BW'(DN - 1));
        // Completing byte bypasses the pack register so the word loads on the same edge.
        word   = pack_q;
        word[DW*(DN-1) +: DW] = in_byte;
        if (load) begin
            pack_d[DW*bcnt_q +: DW] = in_byte;
            bcnt_d = full ? '0 : bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q <= '0;
            pack_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            pack_q <= pack_d;
        end
    end
endmodule

// File: rtl/c_wpack.sv
// Conv weight loader front end: packs a byte stream into DN-byte words with
// bank-local addresses, first/last flags and a ping-pong bank select.
module c_wpack
    import c_pkg::*;
#(
    parameter int unsigned DW = C_DW,
    parameter int unsigned DN = C_DN,
    parameter int unsigned AW = C_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [AW-1:0]    cfg_words,
    output logic             busy,
    output logic             done,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DW*DN-1:0] m_data,
    output logic             m_data_valid,
    input  logic             m_data_ready,
    output logic [AW-1:0]    m_addr,
    output logic             m_addr_first,
    output logic             m_addr_last,
    output logic             m_addr_valid,
    input  logic             m_addr_ready,
    output logic             ram_sel
);
    state_t           state_q, state_d;
    logic [AW-1:0]    words_q, words_d;
    logic [AW-1:0]    wcnt_q, wcnt_d;
    logic [DW*DN-1:0] data_q, data_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;
    logic             sel_q, sel_d;
    logic             done_q, done_d;

    logic             acc;
    logic             load;
    logic             full;
    logic [DW*DN-1:0] word;

    c_bpack #(
        .DW (DW),
        .DN (DN)
    ) u_bpack (
        .clk     (clk),
        .rst     (rst),
        .in_byte (in_data),
        .load    (load),
        .full    (full),
        .word    (word)
    );

    always_comb begin
        acc = valid_q && m_data_ready && m_addr_ready;
        // Once every word of the fill is loaded no further byte may enter the packer.
        in_ready = (state_q == FILL) && (wcnt_q != words_q) && (!valid_q || acc);
        load = in_valid && in_ready;

        state_d = state_q;
        words_d = words_q;
        wcnt_d  = wcnt_q;
        data_d  = data_q;
        addr_d  = addr_q;
        first_d = first_q;
        last_d  = last_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_words != '0) begin
                        state_d = FILL;
                        words_d = cfg_words;
                        wcnt_d  = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (full) begin
                    data_d  = word;
                    addr_d  = wcnt_q;
                    first_d = (wcnt_q == '0);
                    last_d  = (wcnt_q == words_q - 1'b1);
                    valid_d = 1'b1;
                    wcnt_d  = wcnt_q + 1'b1;
                end else if (acc) begin
                    valid_d = 1'b0;
                end
                if (acc && last_q) begin
                    state_d = IDLE;
                    sel_d   = ~sel_q;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            words_q <= '0;
            wcnt_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            wcnt_q  <= wcnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            first_q <= first_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

    assign busy         = (state_q == FILL);
    assign done         = done_q;
    assign m_data       = data_q;
    assign m_data_valid = valid_q;
    assign m_addr       = addr_q;
    assign m_addr_first = first_q;
    assign m_addr_last  = last_q;
    assign m_addr_valid = valid_q;
    assign ram_sel      = sel_q;
endmodule

// File: tb/tb_c_wpack.sv
// Bench for c_wpack: directed fills plus a long random valid/ready run against a word-level model.
module tb_c_wpack;
    localparam int unsigned DW = 8;
    localparam int unsigned DN = 7;
    localparam int unsigned AW = 14;

    typedef struct {
        logic [DW*DN-1:0] data;
        logic [AW-1:0]    addr;
        logic             first;
        logic             last;
        logic             sel;
    } word_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_start = 1'b0;
    logic [AW-1:0]    cfg_words = '0;
    logic             busy, done;
    logic [DW-1:0]    in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW*DN-1:0] m_data;
    logic             m_data_valid;
    logic             m_data_ready = 1'b0;
    logic [AW-1:0]    m_addr;
    logic             m_addr_first, m_addr_last, m_addr_valid;
    logic             m_addr_ready = 1'b0;
    logic             ram_sel;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        exp_sel  = 1'b0;
    word_t       exp_q[$];

    always #5 clk = ~clk;

    c_wpack #(.DW(DW), .DN(DN), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (cfg_start),
        .cfg_words    (cfg_words),
        .busy         (busy),
        .done         (done),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .m_data       (m_data),
        .m_data_valid (m_data_valid),
        .m_data_ready (m_data_ready),
        .m_addr       (m_addr),
        .m_addr_first (m_addr_first),
        .m_addr_last  (m_addr_last),
        .m_addr_valid (m_addr_valid),
        .m_addr_ready (m_addr_ready),
        .ram_sel      (ram_sel)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cfg_start = 1'b0; in_valid = 1'b0; m_data_ready = 1'b0; m_addr_ready = 1'b0;
        exp_sel = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_dvalid", 64'(m_data_valid), 0);
        chk("rst_avalid", 64'(m_addr_valid), 0);
        chk("rst_data", 64'(m_data), 0);
        chk("rst_addr", 64'(m_addr), 0);
        chk("rst_first", 64'(m_addr_first), 0);
        chk("rst_last", 64'(m_addr_last), 0);
        chk("rst_sel", 64'(ram_sel), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One bank fill. Expected words are built directly from the byte list the bench sends.
    task automatic run_fill(input int unsigned n, input bit rnd, input int unsigned base,
                            input int stall_at, input int mid_start_at, input int abort_bytes);
        logic [DW-1:0]    bytes[$];
        int unsigned      total = n * DN;
        int unsigned      bi = 0;
        int               cyc = 0;
        int               budget = int'(n * DN * 10 + 100);
        int               done_cnt = 0;
        bit               hold_pend = 1'b0;
        logic [DW*DN-1:0] hold_data;
        logic [AW-1:0]    hold_addr;
        bit               wacc, bacc;
        word_t            w;

        for (int unsigned i = 0; i < total; i++)
            bytes.push_back(rnd ? DW'($urandom) : DW'(base + i));
        for (int unsigned j = 0; j < n; j++) begin
            for (int unsigned k = 0; k < DN; k++) w.data[DW*k +: DW] = bytes[j*DN + k];
            w.addr  = AW'(j);
            w.first = (j == 0);
            w.last  = (j == n - 1);
            w.sel   = exp_sel;
            exp_q.push_back(w);
        end

        @(negedge clk);
        cfg_start = 1'b1; cfg_words = AW'(n);
        @(negedge clk);
        cfg_start = 1'b0;
        #1 chk("busy_after_start", 64'(busy), 1);

        while (exp_q.size() != 0 && cyc < budget && !(abort_bytes > 0 && bi >= abort_bytes)) begin
            in_valid     = (bi < total) && (!rnd || $urandom_range(3) != 0);
            in_data      = (bi < total) ? bytes[bi] : '0;
            m_data_ready = !rnd || $urandom_range(3) != 0;
            m_addr_ready = !rnd || $urandom_range(7) != 0;
            if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 20) m_data_ready = 1'b0;
            cfg_start = (cyc == mid_start_at);
            cfg_words = (cyc == mid_start_at) ? AW'(9) : AW'(n);
            #1;
            if (done) done_cnt++;
            wacc = m_data_valid && m_data_ready && m_addr_ready;
            bacc = in_valid && in_ready;
            if (hold_pend) begin
                chk("hold_valid", 64'(m_data_valid), 1);
                chk("hold_data", 64'(m_data), 64'(hold_data));
                chk("hold_addr", 64'(m_addr), 64'(hold_addr));
            end
            if (m_data_valid && !wacc) chk("stall_in_ready", 64'(in_ready), 0);
            if (wacc) begin
                w = exp_q.pop_front();
                chk("avalid_eq_dvalid", 64'(m_addr_valid), 1);
                chk("word_data", 64'(m_data), 64'(w.data));
                chk("word_addr", 64'(m_addr), 64'(w.addr));
                chk("word_first", 64'(m_addr_first), 64'(w.first));
                chk("word_last", 64'(m_addr_last), 64'(w.last));
                chk("word_sel", 64'(ram_sel), 64'(w.sel));
            end
            if (bacc) bi++;
            hold_pend = m_data_valid && !wacc;
            hold_data = m_data;
            hold_addr = m_addr;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; cfg_start = 1'b0;

        if (abort_bytes > 0 && bi >= abort_bytes) begin
            exp_q.delete();
            return;
        end
        if (exp_q.size() != 0) begin
            chk("fill_timeout", 64'(exp_q.size()), 0);
            exp_q.delete();
        end
        for (int c = 0; c < 3; c++) begin
            #1 if (done) done_cnt++;
            @(negedge clk);
        end
        chk("done_once", 64'(done_cnt), 1);
        chk("busy_end", 64'(busy), 0);
        exp_sel = ~exp_sel;
        chk("sel_toggled", 64'(ram_sel), 64'(exp_sel));
    endtask

    initial begin
        do_reset();

        // bytes offered while idle are refused
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hAA;
        #1 chk("idle_in_ready", 64'(in_ready), 0);
        @(negedge clk);
        in_valid = 1'b0;

        // basic fill, bytes 0x01..0x15
        run_fill(3, 1'b0, 1, -1, -1, 0);

        // back-to-back fills from reset: sel 0 then 1 then back to 0
        do_reset();
        run_fill(2, 1'b0, 8'h30, -1, -1, 0);
        run_fill(2, 1'b0, 8'h50, -1, -1, 0);
        chk("sel_after_two", 64'(ram_sel), 0);

        // downstream stall of 20 cycles
        run_fill(4, 1'b0, 8'h80, 10, -1, 0);

        // single-word fill
        run_fill(1, 1'b0, 8'hC0, -1, -1, 0);

        // zero-word fill
        @(negedge clk);
        cfg_start = 1'b1; cfg_words = '0;
        @(negedge clk);
        cfg_start = 1'b0;
        #1;
        chk("zero_done", 64'(done), 1);
        chk("zero_busy", 64'(busy), 0);
        chk("zero_sel", 64'(ram_sel), 64'(exp_sel));
        @(negedge clk);
        #1 chk("zero_done_clear", 64'(done), 0);

        // start while busy is ignored
        run_fill(2, 1'b0, 8'h10, -1, 5, 0);

        // reset after 10 bytes, then a clean fill from address 0
        run_fill(3, 1'b0, 8'h20, -1, -1, 10);
        do_reset();
        run_fill(1, 1'b0, 8'h60, -1, -1, 0);

        // long random run
        run_fill(1000, 1'b1, 0, -1, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
